// File: rtl/tt_spi_responder.sv
// SPI mode-0 responder with a small byte-wide register file. SPI pins are
// oversampled on clk; register 0 is exported as a parallel control byte.
module tt_spi_responder #(
  parameter int NUM_REGS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  output logic [7:0] reg0_o,
  output logic       wr_strobe_o,
  output logic [3:0] wr_addr_o,
  output logic       frame_err_o
);

  localparam int         AW         = $clog2(NUM_REGS);
  localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_n_sync_q, mosi_sync_q;
  logic                   sclk_hist_q, cs_n_hist_q;
  logic                   sclk_s, cs_n_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_e     state_q;
  logic [3:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] tx_q;
  logic       write_q;
  logic [3:0] addr_q;
  logic       miso_q, miso_oe_q, wr_strobe_q, frame_err_q;
  logic [3:0] wr_addr_q;
  logic [7:0] reg0_q;
  logic [7:0] regs_q [NUM_REGS];

  logic [3:0] cmd_addr;
  logic [7:0] rd_data;
  logic       addr_ok;

  // CS_N sync/history reset low, so a frame already running at reset is only
  // accepted after the pin is seen high and then low again.
  // NOTE: flops take non-blocking assignments so each stage samples its pre-edge neighbour.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_n_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_n_hist_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_hist_q <= sclk_s;
      cs_n_hist_q <= cs_n_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_n_s    = cs_n_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_rise   = cs_n_s & ~cs_n_hist_q;
  assign cs_fall   = ~cs_n_s & cs_n_hist_q;

  assign cmd_addr = {shift_q[2:0], mosi_s};
  assign addr_ok  = {1'b0, addr_q} < NUM_REGS_W;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    rd_data = 8'h00;
    if ({1'b0, cmd_addr} < NUM_REGS_W) rd_data = regs_q[cmd_addr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
      reg0_q      <= 8'h00;
      // NOTE: the register file is reset explicitly; reads after reset must return 0x00.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      reg0_q      <= regs_q[0];
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_q   <= S_CMD;
            bit_cnt_q <= '0;
            miso_oe_q <= 1'b1;
          end
        end
        S_CMD, S_DATA: begin
          if (cs_rise) begin
            // Abort wins over a coincident SCLK rise; partial frames never touch registers.
            frame_err_q <= (state_q == S_DATA) || (bit_cnt_q != 4'd0);
            state_q     <= S_IDLE;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
          end else if (sclk_rise) begin
            shift_q   <= {shift_q[5:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (state_q == S_CMD && bit_cnt_q == 4'd7) begin
              write_q <= shift_q[6];
              addr_q  <= cmd_addr;
              tx_q    <= shift_q[6] ? 8'h00 : rd_data;
              state_q <= S_DATA;
            end else if (state_q == S_DATA && bit_cnt_q == 4'd15) begin
              if (write_q && addr_ok) begin
                regs_q[addr_q[AW-1:0]] <= {shift_q, mosi_s};
                wr_strobe_q            <= 1'b1;
                wr_addr_q              <= addr_q;
              end
              miso_q  <= 1'b0;
              state_q <= S_DONE;
            end
          end else if (sclk_fall && state_q == S_DATA) begin
            miso_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
          end
        end
        S_DONE: begin
          if (cs_rise) begin
            state_q   <= S_IDLE;
            miso_oe_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign miso_o      = miso_q;
  assign miso_oe_o   = miso_oe_q;
  assign reg0_o      = reg0_q;
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_tt_spi_responder.sv
// Bench for tt_spi_responder: a frame-level initiator drives the pins and a
// transaction model schedules the expected outputs, compared every cycle.
module tb_tt_spi_responder;

  localparam int NUM_REGS    = 8;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 1;
  localparam int MAXC        = 65536;

  logic       clk = 1'b0, rst = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe, wr_strobe, frame_err;
  logic [7:0] reg0;
  logic [3:0] wr_addr;

  tt_spi_responder #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
    .miso_o(miso), .miso_oe_o(miso_oe), .reg0_o(reg0),
    .wr_strobe_o(wr_strobe), .wr_addr_o(wr_addr), .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0, n_errors = 0;
  int unsigned cyc = 0;
  bit          rst_at_edge = 1'b0, started = 1'b0;
  int          strobe_cnt = 0, err_cnt = 0;

  // Expected-output change events, indexed by the clk edge they take effect on.
  bit         ev_oe_v [MAXC];   bit         ev_oe   [MAXC];
  bit         ev_mi_v [MAXC];   bit         ev_mi   [MAXC];
  bit         ev_r0_v [MAXC];   logic [7:0] ev_r0   [MAXC];
  bit         ev_wa_v [MAXC];   logic [3:0] ev_wa   [MAXC];
  bit         p_strobe[MAXC];   bit         p_err   [MAXC];
  bit         e_oe = 1'b0, e_mi = 1'b0, xs, xe;
  logic [7:0] e_r0 = 8'h00;
  logic [3:0] e_wa = 4'h0;

  // Transaction model state.
  logic [7:0]  m_regs [16];
  bit          m_active = 1'b0, m_cs_high = 1'b0, m_read = 1'b0;
  int          m_nbits = 0;
  logic [15:0] m_sr = '0;
  logic [7:0]  m_tx = '0;
  int          half = 4;
  logic [31:0] rx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_oe(input int c, input bit v);
    if (c < MAXC) begin ev_oe_v[c] = 1'b1; ev_oe[c] = v; end
  endtask
  task automatic s_mi(input int c, input bit v);
    if (c < MAXC) begin ev_mi_v[c] = 1'b1; ev_mi[c] = v; end
  endtask
  task automatic s_r0(input int c, input logic [7:0] v);
    if (c < MAXC) begin ev_r0_v[c] = 1'b1; ev_r0[c] = v; end
  endtask
  task automatic s_wa(input int c, input logic [3:0] v);
    if (c < MAXC) begin ev_wa_v[c] = 1'b1; ev_wa[c] = v; end
  endtask

  task automatic cs_fall_t();
    cs_n = 1'b0;
    if (m_cs_high) begin
      m_active = 1'b1; m_nbits = 0; m_sr = '0; m_read = 1'b0; m_tx = '0;
      s_oe(cyc + LAT, 1'b1);
    end
    m_cs_high = 1'b0;
  endtask

  task automatic cs_rise_t();
    cs_n = 1'b1;
    if (m_active) begin
      if (m_nbits > 0 && m_nbits < 16 && cyc + LAT < MAXC) p_err[cyc + LAT] = 1'b1;
      s_oe(cyc + LAT, 1'b0);
      s_mi(cyc + LAT, 1'b0);
    end
    m_active  = 1'b0;
    m_cs_high = 1'b1;
  endtask

  task automatic send_bit(input logic b);
    int a;
    mosi = b;
    repeat (half) tick();
    sclk = 1'b1;
    rx   = {rx[30:0], miso};
    if (m_active && m_nbits < 16) begin
      m_sr = {m_sr[14:0], b};
      m_nbits++;
      if (m_nbits == 8) begin
        a      = int'(m_sr[3:0]);
        m_read = ~m_sr[7];
        m_tx   = (m_read && a < NUM_REGS) ? m_regs[a] : 8'h00;
      end else if (m_nbits == 16) begin
        a = int'(m_sr[11:8]);
        if (!m_read && a < NUM_REGS) begin
          m_regs[a] = m_sr[7:0];
          if (cyc + LAT < MAXC) p_strobe[cyc + LAT] = 1'b1;
          s_wa(cyc + LAT, m_sr[11:8]);
          if (a == 0) s_r0(cyc + LAT + 1, m_sr[7:0]);
        end
        s_mi(cyc + LAT, 1'b0);
      end
    end
    repeat (half) tick();
    sclk = 1'b0;
    if (m_active && m_read && m_nbits >= 8 && m_nbits < 16) s_mi(cyc + LAT, m_tx[15 - m_nbits]);
  endtask

  // w is left-aligned: the first bit on the wire is w[31].
  task automatic frame(input logic [31:0] w, input int nbits, input bit fall, input bit rise);
    rx = '0;
    if (fall) cs_fall_t();
    for (int i = 0; i < nbits; i++) send_bit(w[31 - i]);
    repeat (half) tick();
    if (rise) begin
      cs_rise_t();
      repeat (half) tick();
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    frame({4'h8, a, d, 16'h0000}, 16, 1'b1, 1'b1);
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    frame({4'h0, a, 8'h00, 16'h0000}, 16, 1'b1, 1'b1);
    d = rx[7:0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_active = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    repeat (2) tick();
    rst = 1'b0;
    m_cs_high = cs_n;
    repeat (4) tick();
  endtask

  always @(posedge clk) begin
    cyc         = cyc + 1;
    rst_at_edge = rst;
  end

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      if (rst_at_edge) begin
        e_oe = 1'b0; e_mi = 1'b0; e_r0 = 8'h00; e_wa = 4'h0;
        xs = 1'b0; xe = 1'b0;
        started = 1'b1;
      end else begin
        if (ev_oe_v[cyc]) e_oe = ev_oe[cyc];
        if (ev_mi_v[cyc]) e_mi = ev_mi[cyc];
        if (ev_r0_v[cyc]) e_r0 = ev_r0[cyc];
        if (ev_wa_v[cyc]) e_wa = ev_wa[cyc];
        xs = p_strobe[cyc];
        xe = p_err[cyc];
      end
      if (started) begin
        check("miso_o", 32'(miso), 32'(e_mi));
        check("miso_oe_o", 32'(miso_oe), 32'(e_oe));
        check("reg0_o", 32'(reg0), 32'(e_r0));
        check("wr_addr_o", 32'(wr_addr), 32'(e_wa));
        check("wr_strobe_o", 32'(wr_strobe), 32'(xs));
        check("frame_err_o", 32'(frame_err), 32'(xe));
      end
    end
    if (wr_strobe === 1'b1) strobe_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  initial begin
    #(64'(MAXC) * 10 - 100);
    $display("FAIL watchdog: simulation exceeded %0d cycles", MAXC);
    $fatal(1);
  end

  initial begin
    logic [7:0]  d;
    logic [31:0] w;
    int          s0, e0, nb;

    do_reset();
    check("reset reg0", 32'(reg0), 32'h00);
    check("reset oe", 32'(miso_oe), 32'h0);

    s0 = strobe_cnt;
    wr(4'd0, 8'hA5);
    check("wr0 strobes", 32'(strobe_cnt - s0), 32'd1);
    check("wr0 reg0", 32'(reg0), 32'hA5);
    check("wr0 waddr", 32'(wr_addr), 32'h0);
    check("wr0 miso bits", rx, 32'h0);

    wr(4'd5, 8'h3C);
    rd(4'd5, d);
    check("rd5 data", 32'(d), 32'h3C);

    rd(4'd9, d);
    check("rd9 data", 32'(d), 32'h00);
    s0 = strobe_cnt;
    wr(4'd9, 8'hFF);
    check("wr9 strobes", 32'(strobe_cnt - s0), 32'd0);
    rd(4'd1, d);
    check("wr9 no alias", 32'(d), 32'h00);

    wr(4'd1, 8'h5A);
    e0 = err_cnt;
    frame({8'h81, 8'hC3, 16'h0000}, 11, 1'b1, 1'b1);
    check("abort errs", 32'(err_cnt - e0), 32'd1);
    rd(4'd1, d);
    check("abort reg1", 32'(d), 32'h5A);

    s0 = strobe_cnt;
    frame({8'h82, 8'h11, 4'b1011, 12'h000}, 20, 1'b1, 1'b1);
    check("20clk strobes", 32'(strobe_cnt - s0), 32'd1);
    rd(4'd2, d);
    check("20clk reg2", 32'(d), 32'h11);

    wr(4'd0, 8'h77);
    check("pre-rst reg0", 32'(reg0), 32'h77);
    s0 = strobe_cnt;
    e0 = err_cnt;
    w  = {8'h80, 8'hFF, 16'h0000};
    frame(w, 12, 1'b1, 1'b0);
    repeat (6) tick();
    do_reset();
    check("mid-rst reg0", 32'(reg0), 32'h00);
    frame(w << 12, 4, 1'b0, 1'b1);
    check("mid-rst strobes", 32'(strobe_cnt - s0), 32'd0);
    check("mid-rst errs", 32'(err_cnt - e0), 32'd0);
    wr(4'd0, 8'h42);
    check("post-rst reg0", 32'(reg0), 32'h42);

    repeat (40) begin
      half = int'($urandom_range(4, 7));
      w    = $urandom();
      w[31:24] = {w[31], 3'($urandom_range(0, 7)), 4'($urandom_range(0, 9))};
      case ($urandom_range(0, 9))
        6:       nb = int'($urandom_range(0, 15));
        7:       nb = int'($urandom_range(17, 20));
        default: nb = 16;
      endcase
      frame(w, nb, 1'b1, 1'b1);
    end
    half = 4;
    for (int a = 0; a < NUM_REGS; a++) rd(4'(a), d);
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
